// File: rtl/fetch_address_gen.sv
// fetch_address_gen: instruction-fetch address generator.
// Holds the fetch PC, selects the next PC (redirect > prediction > sequential),
// issues word-aligned fetch requests and tracks in-flight requests in a tag FIFO
// carrying prediction metadata and discard flags back to decode.
// Optional build macro FETCH_PC_TMR_EN: triplicated, self-scrubbing PC register.
module fetch_address_gen #(
    parameter logic [31:0] BOOT_ADD        = 32'h0000_0080,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_stall_i,
    input  logic        s_redirect_i,
    input  logic [31:0] s_redirect_add_i,
    input  logic        s_pred_branch_i,
    input  logic [31:0] s_pred_add_i,
    input  logic        s_ualigc_i,
    output logic [30:0] s_fetch_add_o,
    output logic        s_hreq_o,
    output logic [31:0] s_haddr_o,
    input  logic        s_hready_i,
    input  logic        s_hrvalid_i,
    output logic        s_rsp_valid_o,
    output logic        s_rsp_pred_o,
    output logic        s_rsp_ualigc_o,
    output logic        s_rsp_discard_o,
    output logic        s_err_o,
    output logic        s_pc_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [30:0]   BOOT_PC  = BOOT_ADD[31:1];

    typedef struct packed {
        logic pred;
        logic ualigc;
        logic discard;
    } tag_t;

    tag_t          fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    logic [30:0] pc_cur;     // voted / single PC, PC[31:1]
    logic [30:0] pc_next;
    logic        accept, pop;
    tag_t        push_tag;

    logic rsp_valid_q, rsp_pred_q, rsp_ualigc_q, rsp_discard_q, err_q;

    // Bit 0 of both target addresses is meaningless for a halfword-granular PC.
    logic unused_addr_bits;
    assign unused_addr_bits = s_redirect_add_i[0] ^ s_pred_add_i[0];

    // Request handshake and FIFO control
    assign s_hreq_o  = ~s_reset_i & ~s_stall_i & (count_q < MAX_CNT);
    assign accept    = s_hreq_o & s_hready_i;
    assign pop       = s_hrvalid_i & (count_q != '0);
    // A request taken in the redirect cycle fetched the wrong path already.
    assign push_tag  = '{pred: s_pred_branch_i & ~s_redirect_i,
                         ualigc: s_ualigc_i,
                         discard: s_redirect_i};

    assign s_fetch_add_o = pc_cur;
    assign s_haddr_o     = {pc_cur[30:1], 2'b00};

    // Next-PC priority: redirect, taken prediction, sequential word, hold
    always_comb begin
        pc_next = pc_cur;
        if (s_redirect_i)
            pc_next = s_redirect_add_i[31:1];
        else if (accept && s_pred_branch_i)
            pc_next = s_pred_add_i[31:1];
        else if (accept)
            pc_next = {pc_cur[30:1] + 30'd1, 1'b0};
    end

`ifdef FETCH_PC_TMR_EN
    logic [30:0] pc_a, pc_b, pc_c;
    assign pc_cur     = (pc_a & pc_b) | (pc_a & pc_c) | (pc_b & pc_c);
    assign s_pc_err_o = ~s_reset_i & ((pc_a != pc_cur) | (pc_b != pc_cur) | (pc_c != pc_cur));

    // All three copies reload from the voted next value, scrubbing any upset
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            pc_a <= BOOT_PC;
            pc_b <= BOOT_PC;
            pc_c <= BOOT_PC;
        end else begin
            pc_a <= pc_next;
            pc_b <= pc_next;
            pc_c <= pc_next;
        end
    end
`else
    logic [30:0] pc_q;
    assign pc_cur     = pc_q;
    assign s_pc_err_o = 1'b0;

    // Single PC register
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) pc_q <= BOOT_PC;
        else           pc_q <= pc_next;
    end
`endif

    // Tag FIFO storage: flush marks every entry, a same-cycle push overrides its slot
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            if (s_redirect_i)
                for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i].discard <= 1'b1;
            if (accept)
                fifo_q[wptr_q] <= push_tag;
        end
    end

    // FIFO pointers and outstanding counter
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            if (pop)    rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered response to decode; a popped entry hit by a redirect is stale too
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_pred_q    <= 1'b0;
            rsp_ualigc_q  <= 1'b0;
            rsp_discard_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rsp_valid_q   <= pop;
            rsp_pred_q    <= pop & fifo_q[rptr_q].pred;
            rsp_ualigc_q  <= pop & fifo_q[rptr_q].ualigc;
            rsp_discard_q <= pop & (fifo_q[rptr_q].discard | s_redirect_i);
            err_q         <= (s_hrvalid_i & (count_q == '0)) |
                             (accept & (count_q >= MAX_CNT));
        end
    end

    assign s_rsp_valid_o   = rsp_valid_q & ~s_reset_i;
    assign s_rsp_pred_o    = rsp_pred_q;
    assign s_rsp_ualigc_o  = rsp_ualigc_q;
    assign s_rsp_discard_o = rsp_discard_q;
    assign s_err_o         = err_q & ~s_reset_i;

endmodule

// File: tb/tb_fetch_address_gen.sv
// Bench for fetch_address_gen: reference model of PC/counter plus a scoreboard of
// expected response tags, pushed when a response is requested, popped on output.
module tb_fetch_address_gen;

    localparam logic [31:0] BOOT = 32'h0000_0080;
    localparam int          MAXO = 2;

    typedef struct packed {
        logic pred;
        logic ualigc;
        logic discard;
    } tag_t;

    logic        clk = 1'b0;
    logic        rst, stall, redir, pred, ualigc, hready, hrvalid;
    logic [31:0] radd, padd;
    logic [30:0] fetch_add;
    logic        hreq;
    logic [31:0] haddr;
    logic        rsp_valid, rsp_pred, rsp_ualigc, rsp_discard, err, pc_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = BOOT;
    tag_t        tq[$];   // model of in-flight request tags
    tag_t        rq[$];   // scoreboard of expected responses

    always #5 clk = ~clk;

    fetch_address_gen #(.BOOT_ADD(BOOT), .MAX_OUTSTANDING(MAXO)) dut (
        .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall),
        .s_redirect_i(redir), .s_redirect_add_i(radd),
        .s_pred_branch_i(pred), .s_pred_add_i(padd), .s_ualigc_i(ualigc),
        .s_fetch_add_o(fetch_add), .s_hreq_o(hreq), .s_haddr_o(haddr),
        .s_hready_i(hready), .s_hrvalid_i(hrvalid),
        .s_rsp_valid_o(rsp_valid), .s_rsp_pred_o(rsp_pred),
        .s_rsp_ualigc_o(rsp_ualigc), .s_rsp_discard_o(rsp_discard),
        .s_err_o(err), .s_pc_err_o(pc_err)
    );

    task automatic idle();
        rst = 0; stall = 0; redir = 0; pred = 0; ualigc = 0;
        hready = 0; hrvalid = 0; radd = 0; padd = 0;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cyc();
        logic exp_hreq, acc, exp_rv, exp_err;
        tag_t t, got;
        #2;
        exp_hreq = !rst && !stall && (tq.size() < MAXO);
        checks++;
        if (hreq !== exp_hreq) begin
            errors++; $display("FAIL hreq got %0b exp %0b", hreq, exp_hreq);
        end
        if (exp_hreq) begin
            checks++;
            if (haddr !== {m_pc[31:2], 2'b00}) begin
                errors++; $display("FAIL haddr got %h exp %h", haddr, {m_pc[31:2], 2'b00});
            end
            checks++;
            if (fetch_add !== m_pc[31:1]) begin
                errors++; $display("FAIL fetch_add got %h exp %h", fetch_add, m_pc[31:1]);
            end
        end
        checks++;
        if (pc_err !== 1'b0) begin
            errors++; $display("FAIL pc_err got %b exp 0", pc_err);
        end
        acc     = exp_hreq && hready;
        exp_rv  = !rst && hrvalid && (tq.size() != 0);
        exp_err = !rst && hrvalid && (tq.size() == 0);
        if (rst) begin
            tq.delete();
            m_pc = BOOT & ~32'd1;
        end else begin
            if (exp_rv) begin
                t = tq.pop_front();
                t.discard = t.discard | redir;
                rq.push_back(t);
            end
            if (redir) foreach (tq[i]) tq[i].discard = 1'b1;
            if (acc) begin
                t.pred = pred & ~redir; t.ualigc = ualigc; t.discard = redir;
                tq.push_back(t);
            end
            if (redir)              m_pc = radd & ~32'd1;
            else if (acc && pred)   m_pc = padd & ~32'd1;
            else if (acc)           m_pc = {m_pc[31:2] + 30'd1, 2'b00};
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== exp_rv) begin
            errors++; $display("FAIL rsp_valid got %b exp %b", rsp_valid, exp_rv);
        end
        if (exp_rv) begin
            t = rq.pop_front();
            got = '{pred: rsp_pred, ualigc: rsp_ualigc, discard: rsp_discard};
            checks++;
            if (got !== t) begin
                errors++; $display("FAIL rsp_tag got %b exp %b", got, t);
            end
        end
        checks++;
        if (err !== exp_err) begin
            errors++; $display("FAIL err got %b exp %b", err, exp_err);
        end
    endtask

    task automatic drain();
        idle(); hrvalid = 1;
        while (tq.size() != 0) cyc();
        idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        cyc(); cyc();
        checks++;
        if ({hreq, rsp_valid, err, pc_err} !== 4'b0 || fetch_add !== 31'h40) begin
            errors++; $display("FAIL reset_state got %b/%h exp 0000/40",
                               {hreq, rsp_valid, err, pc_err}, fetch_add);
        end
        idle();
    endtask

    task automatic test_sequential();
        idle(); hready = 1;
        cyc(); cyc(); cyc();      // 0x80, 0x84, then saturated
        checks++;
        if (hreq !== 1'b0) begin
            errors++; $display("FAIL saturate_hreq got %b exp 0", hreq);
        end
        drain();
        hready = 1; #2;
        checks++;
        if (haddr !== 32'h88) begin
            errors++; $display("FAIL seq_haddr got %h exp 00000088", haddr);
        end
        cyc();
        drain();
    endtask

    task automatic test_pred();
        idle(); redir = 1; radd = 32'h100;
        cyc();
        idle(); hready = 1; pred = 1; padd = 32'h236;
        cyc();
        idle();
        checks++;
        if (fetch_add !== 31'h11B || haddr !== 32'h234) begin
            errors++; $display("FAIL pred_target got %h/%h exp 11b/00000234", fetch_add, haddr);
        end
        drain();
    endtask

    task automatic test_flush();
        idle(); hready = 1;
        cyc(); cyc();
        idle(); redir = 1; radd = 32'h400;
        cyc();
        drain();
        hready = 1; cyc();
        drain();
    endtask

    task automatic test_redirect_accept();
        idle(); hready = 1; pred = 1; padd = 32'h900; ualigc = 1; redir = 1; radd = 32'h500;
        cyc();
        idle();
        checks++;
        if (fetch_add !== 31'h280) begin
            errors++; $display("FAIL redir_over_pred got %h exp 280", fetch_add);
        end
        drain();
    endtask

    task automatic test_err_and_simul();
        idle(); hrvalid = 1; cyc();     // no request outstanding
        idle(); cyc();                  // err clears
        hready = 1; cyc();              // count 1
        hrvalid = 1; cyc();             // accept + pop: count stays 1
        hrvalid = 0; cyc();             // count 2
        cyc();                          // hreq must be low now
        drain();
    endtask

    task automatic test_stall_wrap();
        idle(); redir = 1; radd = 32'hFFFF_FFFC; cyc();
        idle(); hready = 1; cyc();
        stall = 1; hrvalid = 1; cyc();  // response completes under stall
        idle();
        checks++;
        if (fetch_add !== 31'h0) begin
            errors++; $display("FAIL wrap got %h exp 0", fetch_add);
        end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom % 50) == 0;
            stall   = ($urandom % 4) == 0;
            hready  = ($urandom % 3) != 0;
            hrvalid = ($urandom % 2) == 0;
            redir   = ($urandom % 8) == 0;
            pred    = ($urandom % 3) == 0;
            ualigc  = ($urandom % 2) == 0;
            radd    = $urandom;
            padd    = $urandom;
            cyc();
        end
        drain();
    endtask

`ifdef FETCH_PC_TMR_EN
    task automatic test_pc_tmr();
        logic [30:0] bad;
        idle(); #2;
        bad = dut.pc_b ^ 31'h4;
        force dut.pc_b = bad;
        #1;
        checks++;
        if (fetch_add !== m_pc[31:1] || pc_err !== 1'b1) begin
            errors++; $display("FAIL tmr_upset got %h/%b exp %h/1", fetch_add, pc_err, m_pc[31:1]);
        end
        release dut.pc_b;
        @(posedge clk); #1;
        checks++;
        if (fetch_add !== m_pc[31:1] || pc_err !== 1'b0) begin
            errors++; $display("FAIL tmr_scrub got %h/%b exp %h/0", fetch_add, pc_err, m_pc[31:1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_pred();
        test_flush();
        test_redirect_accept();
        test_err_and_simul();
        test_stall_wrap();
`ifdef FETCH_PC_TMR_EN
        test_pc_tmr();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
